// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types for the unified memory arbiter: FSM state encoding and requester IDs.
package unified_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StBusyIf = 2'd1,
    StBusyD  = 2'd2
  } arb_state_e;

  typedef logic req_id_t;

  localparam req_id_t ReqIf = 1'b0;
  localparam req_id_t ReqD  = 1'b1;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Bundle of requester (fetch, data) and memory-port signals around the unified memory arbiter.
interface unified_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  logic              err;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  // Environment side: requesters and the memory.
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    input  if_ack, if_rdata, d_ack, d_rdata, err, mem_req, mem_we, mem_addr, mem_wdata
  );

  // Arbiter side.
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    output if_ack, if_rdata, d_ack, d_rdata, err, mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_watchdog.sv
// Busy-cycle watchdog: counts enabled cycles and flags the edge on which the count reaches TIMEOUT.
module mem_watchdog #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CntW    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned LastCnt = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  // Expires on the edge that would bring the count up to TIMEOUT; TIMEOUT=0 never expires.
  assign expired = (TIMEOUT != 0) && en && (cnt_q == CntW'(LastCnt));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between instruction fetch and
// load/store, with registered memory port, one-cycle acks and a timeout abort.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  unified_mem_arbiter_if.slave bus
);

  arb_state_e        state_q, state_d;
  req_id_t           last_q, last_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_elig, d_elig;
  logic              wd_clr, wd_en, wd_expired;

  mem_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (wd_clr),
    .en     (wd_en),
    .expired(wd_expired)
  );

  // A requester being acked this cycle may still hold req high for the finished transfer.
  assign if_elig = bus.if_req && !if_ack_q;
  assign d_elig  = bus.d_req && !d_ack_q;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    err_d       = 1'b0;
    wd_clr      = 1'b0;
    wd_en       = 1'b0;

    unique case (state_q)
      StIdle: begin
        wd_clr = 1'b1;
        if (d_elig && (!if_elig || last_q == ReqIf)) begin
          state_d     = StBusyD;
          last_d      = ReqD;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.d_we;
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_wdata;
        end else if (if_elig) begin
          state_d     = StBusyIf;
          last_d      = ReqIf;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.if_addr;
          mem_wdata_d = '0;
        end
      end
      StBusyIf, StBusyD: begin
        wd_en = !bus.mem_ack;
        // mem_ack takes priority over a watchdog expiry on the same edge.
        if (bus.mem_ack || wd_expired) begin
          state_d   = StIdle;
          mem_req_d = 1'b0;
          err_d     = !bus.mem_ack;
          if (state_q == StBusyIf) begin
            if_ack_d   = 1'b1;
            if_rdata_d = bus.mem_ack ? bus.mem_rdata : '0;
          end else begin
            d_ack_d = 1'b1;
            if (!bus.mem_ack) begin
              d_rdata_d = '0;
            end else if (!mem_we_q) begin
              d_rdata_d = bus.mem_rdata;
            end
          end
        end
      end
      default: begin
        state_d   = StIdle;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      last_q      <= ReqIf;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      err_q       <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      err_q       <= err_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.err       = err_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed scenarios plus randomized requesters and memory,
// checked cycle by cycle against a transaction-level reference model.
module tb_unified_mem_arbiter;

  localparam int unsigned AddrW   = 32;
  localparam int unsigned DataW   = 32;
  localparam int unsigned Timeout = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  unified_mem_arbiter_if #(.ADDR_W(AddrW), .DATA_W(DataW)) bus ();

  unified_mem_arbiter #(
    .ADDR_W (AddrW),
    .DATA_W (DataW),
    .TIMEOUT(Timeout)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: owner 0=none, 1=fetch, 2=data; busy_n = edges spent waiting so far.
  int          own;
  int          busy_n;
  bit          last_d;
  logic        e_if_ack, e_d_ack, e_err, e_mem_req, e_mem_we;
  logic [31:0] e_if_rdata, e_d_rdata, e_mem_addr, e_mem_wdata;

  task automatic model_reset();
    own = 0; busy_n = 0; last_d = 1'b0;
    e_if_ack = 0; e_d_ack = 0; e_err = 0; e_mem_req = 0; e_mem_we = 0;
    e_if_rdata = 0; e_d_rdata = 0; e_mem_addr = 0; e_mem_wdata = 0;
  endtask

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic model_edge();
    bit ei, ed, done, abort, n_if_ack, n_d_ack;
    int g;
    n_if_ack = 0; n_d_ack = 0; done = 0; abort = 0; g = 0;
    if (own == 0) begin
      ei = bus.if_req && !e_if_ack;
      ed = bus.d_req && !e_d_ack;
      if (ei && ed) g = last_d ? 1 : 2;
      else if (ed) g = 2;
      else if (ei) g = 1;
      if (g != 0) begin
        own         = g;
        busy_n      = 0;
        last_d      = (g == 2);
        e_mem_req   = 1;
        e_mem_addr  = (g == 2) ? bus.d_addr : bus.if_addr;
        e_mem_we    = (g == 2) && bus.d_we;
        e_mem_wdata = (g == 2) ? bus.d_wdata : 32'h0;
      end
    end else begin
      if (bus.mem_ack) done = 1;
      else if (busy_n + 1 == Timeout) begin done = 1; abort = 1; end
      else busy_n++;
      if (done) begin
        if (own == 1) begin
          n_if_ack   = 1;
          e_if_rdata = abort ? 32'h0 : bus.mem_rdata;
        end else begin
          n_d_ack = 1;
          if (abort) e_d_rdata = 32'h0;
          else if (!e_mem_we) e_d_rdata = bus.mem_rdata;
        end
        e_mem_req = 0;
        own       = 0;
      end
    end
    e_if_ack = n_if_ack;
    e_d_ack  = n_d_ack;
    e_err    = abort;
  endtask

  task automatic compare_all();
    check("if_ack", bus.if_ack, e_if_ack);
    check("d_ack", bus.d_ack, e_d_ack);
    check("err", bus.err, e_err);
    check("if_rdata", bus.if_rdata, e_if_rdata);
    check("d_rdata", bus.d_rdata, e_d_rdata);
    check("mem_req", bus.mem_req, e_mem_req);
    check("mem_we", bus.mem_we, e_mem_we);
    check("mem_addr", bus.mem_addr, e_mem_addr);
    check("mem_wdata", bus.mem_wdata, e_mem_wdata);
  endtask

  // Called at a falling edge with inputs set: model the edge, advance, then compare.
  task automatic cycle();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  // Memory responder: acks on the lat-th cycle of a request; lat_cfg<0 picks 1..6 at random.
  int          lat_cfg;
  int          cur_lat;
  int          mem_wait;
  bit          fix_data_en;
  bit          spurious_en;
  logic [31:0] fix_data;

  task automatic drive_mem();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = fix_data_en ? fix_data : $urandom;
    if (bus.mem_req) begin
      mem_wait++;
      if (mem_wait == cur_lat) bus.mem_ack = 1'b1;
    end else begin
      mem_wait = 0;
      cur_lat  = (lat_cfg < 0) ? int'($urandom_range(1, 6)) : lat_cfg;
      if (spurious_en && $urandom_range(0, 15) == 0) bus.mem_ack = 1'b1;
    end
  endtask

  // Random requesters: after an ack, either drop or issue a new request in the next cycle.
  bit if_seen, d_seen;

  task automatic new_if();
    bus.if_req  = 1'b1;
    bus.if_addr = $urandom;
  endtask

  task automatic new_d();
    bus.d_req   = 1'b1;
    bus.d_we    = 1'($urandom_range(0, 1));
    bus.d_addr  = $urandom;
    bus.d_wdata = $urandom;
  endtask

  task automatic drive_reqs();
    if (if_seen) begin
      if_seen = 0;
      if ($urandom_range(0, 1) == 1) new_if();
      else bus.if_req = 1'b0;
    end else if (!bus.if_req && $urandom_range(0, 2) == 0) begin
      new_if();
    end
    if (bus.if_ack) if_seen = 1;
    if (d_seen) begin
      d_seen = 0;
      if ($urandom_range(0, 1) == 1) new_d();
      else bus.d_req = 1'b0;
    end else if (!bus.d_req && $urandom_range(0, 2) == 0) begin
      new_d();
    end
    if (bus.d_ack) d_seen = 1;
  endtask

  task automatic wait_ack(input bit want_d, output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      drive_mem();
      cycle();
      n = i;
      if (want_d ? bus.d_ack : bus.if_ack) break;
    end
  endtask

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) begin
      drive_mem();
      cycle();
    end
  endtask

  initial begin
    int n;
    int grants[$];
    logic prev_req;

    bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = 0; bus.d_wdata = 0; bus.mem_rdata = 0; bus.mem_ack = 0;
    lat_cfg = 1; cur_lat = 1; mem_wait = 0; fix_data_en = 1; fix_data = 0; spurious_en = 0;
    if_seen = 0; d_seen = 0;
    model_reset();

    // Reset values
    repeat (2) @(negedge clk);
    compare_all();
    rst_n = 1'b1;
    idle_cycles(2);

    // Single fetch, memory acks one cycle after mem_req
    lat_cfg = 2; fix_data = 32'h2001_0008;
    bus.if_req = 1; bus.if_addr = 32'h0000_0004;
    wait_ack(1'b0, n);
    check("fetch_latency", n, 3);
    check("fetch_rdata", bus.if_rdata, 32'h2001_0008);
    check("fetch_mem_addr", bus.mem_addr, 32'h4);
    check("fetch_mem_we", bus.mem_we, 0);
    bus.if_req = 0;
    idle_cycles(2);

    // Store, zero-wait memory
    lat_cfg = 1;
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h10; bus.d_wdata = 32'hDEAD_BEEF;
    wait_ack(1'b1, n);
    check("store_latency", n, 2);
    check("store_mem_we", bus.mem_we, 1);
    check("store_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    check("store_rdata_kept", bus.d_rdata, 32'h0);
    bus.d_req = 0; bus.d_we = 0;
    idle_cycles(2);

    // Reset in the middle of a data transaction
    lat_cfg = 99;
    bus.d_req = 1; bus.d_addr = 32'h80;
    idle_cycles(2);
    check("pre_rst_mem_req", bus.mem_req, 1);
    #2 rst_n = 1'b0;
    #1 check("rst_mem_req_async", bus.mem_req, 0);
    check("rst_d_ack", bus.d_ack, 0);
    model_reset();
    bus.d_req = 0;
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
    idle_cycles(3);
    check("rst_no_late_ack", bus.d_ack, 0);

    // Contention: both held high, tie after reset goes to data first
    lat_cfg = 1; fix_data = 32'h1234_5678;
    bus.if_req = 1; bus.if_addr = 32'h100;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h200;
    prev_req = 0;
    for (int i = 0; i < 20; i++) begin
      drive_mem();
      cycle();
      if (bus.mem_req && !prev_req) grants.push_back((bus.mem_addr == 32'h200) ? 2 : 1);
      prev_req = bus.mem_req;
    end
    check("contention_grants", grants.size() >= 6, 1);
    for (int i = 0; i < 6 && i < grants.size(); i++) begin
      check($sformatf("contention_grant%0d", i), grants[i], (i % 2 == 0) ? 2 : 1);
    end
    bus.if_req = 0; bus.d_req = 0;
    idle_cycles(4);
    check("pre_timeout_rdata", bus.d_rdata, 32'h1234_5678);

    // Timeout on a load with a fetch waiting behind it
    lat_cfg = 99;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h40;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      drive_mem();
      cycle();
      n = i;
      if (i == 1) begin bus.if_req = 1; bus.if_addr = 32'h300; end
      if (bus.d_ack) break;
    end
    check("timeout_latency", n, 5);
    check("timeout_err", bus.err, 1);
    check("timeout_rdata", bus.d_rdata, 32'h0);
    check("timeout_mem_req", bus.mem_req, 0);
    bus.d_req = 0;
    lat_cfg = 1;
    drive_mem();
    cycle();
    check("after_timeout_grant_req", bus.mem_req, 1);
    check("after_timeout_grant_addr", bus.mem_addr, 32'h300);
    wait_ack(1'b0, n);
    check("after_timeout_fetch_ack", bus.if_ack, 1);
    bus.if_req = 0;
    idle_cycles(2);

    // mem_ack on exactly the timeout cycle
    lat_cfg = 4; fix_data = 32'hCAFE_F00D;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h44;
    wait_ack(1'b1, n);
    check("race_latency", n, 5);
    check("race_err", bus.err, 0);
    check("race_rdata", bus.d_rdata, 32'hCAFE_F00D);
    bus.d_req = 0;
    idle_cycles(2);

    // Randomized traffic
    lat_cfg = -1; fix_data_en = 0; spurious_en = 1;
    for (int i = 0; i < 3000; i++) begin
      drive_reqs();
      drive_mem();
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-ported unified memory between two requesters of the multi-cycle CPU: instruction fetch (IF) and data access (D, lw/sw).
- Sits between the PC/IR fetch path, the load/store path and the memory.
- Grants one request at a time with round-robin fairness, registers address, write data and write enable into the memory port, and returns read data with a one-cycle ack.
- A watchdog aborts transactions the memory never acknowledges.

Parameters:
ADDR_W, 32, address width in bits
DATA_W, 32, data width in bits
TIMEOUT, 16, max cycles in BUSY before abort; 0 disables watchdog; counter width $clog2(TIMEOUT+1), min 1

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous, active-low reset
if_req  in  1  fetch request, level, held until if_ack
if_addr  in  ADDR_W  fetch address
if_ack  out  1  one-cycle completion pulse
if_rdata  out  DATA_W  fetched word, valid while if_ack=1, held afterward
d_req  in  1  data request, level, held until d_ack
d_we  in  1  1=store, 0=load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_ack  out  1  one-cycle completion pulse
d_rdata  out  DATA_W  load word, valid while d_ack=1, held afterward
err  out  1  pulses with the ack of a timed-out transaction
mem_req  out  1  memory request, held until mem_ack or abort
mem_we  out  1  memory write enable (0 for IF)
mem_addr  out  ADDR_W  registered address
mem_wdata  out  DATA_W  registered write data
mem_rdata  in  DATA_W  memory read data, valid with mem_ack
mem_ack  in  1  memory completion, one cycle

Behaviour:
- Reset (RST=0, asynchronous):
  - State goes to IDLE; last_grant=IF, so D wins the first tie.
  - All outputs are 0, including rdata registers; watchdog count is 0.
  - mem_req drops immediately, even mid-transaction. An in-flight transaction is discarded and no ack is issued.
- States: IDLE, BUSY_IF, BUSY_D.
- IDLE:
  - Ignore the requester whose ack is high this cycle, since its req may still be asserted.
  - One eligible request: grant it.
  - Both eligible: grant the one not equal to last_grant.
  - On grant, at the next edge: latch addr, we and wdata into the mem_* registers; set mem_req=1; update last_grant; clear the counter; move to BUSY_x.
  - No request: stay in IDLE.
- BUSY_x:
  - mem_req=1 and mem_* are stable.
  - mem_ack=1 on an edge:
    - Capture mem_rdata into x_rdata; for a store, x_rdata is left unchanged.
    - Pulse x_ack for the next cycle.
    - Set mem_req=0 and return to IDLE.
  - Otherwise increment the counter. When the counter equals TIMEOUT (TIMEOUT≠0) at an edge with mem_ack=0:
    - Abort: mem_req=0, x_ack=1, err=1 for one cycle, x_rdata=0.
    - Return to IDLE.
  - mem_ack and the timeout in the same cycle: mem_ack wins and err=0.
  - mem_ack while IDLE is ignored.
- Latency:
  - req rises in cycle 0 while IDLE → mem_req=1 in cycle 1.
  - Zero-wait memory (mem_ack in cycle 1) → ack in cycle 2, so 2 cycles minimum.
  - In general, mem_ack in cycle k → ack in cycle k+1.
- Throughput: back-to-back requests are granted one cycle after the ack cycle. The ack cycle is IDLE with the acked requester masked; the other requester can be granted in that same cycle.
- Requester rule: drop req in the cycle after seeing ack, or keep it high to issue a new request. The mask covers only the ack cycle.
- Inputs from the requester are sampled only at grant. Changes while BUSY have no effect.
- At most one of if_ack and d_ack is high in any cycle.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=2'd0, BUSY_IF=2'd1, BUSY_D=2'd2
  - requester ID constants: REQ_IF=1'b0, REQ_D=1'b1
- One sub-module: mem_watchdog, the timeout counter with clear/enable/expired and TIMEOUT parameter, reusable by a later I/O bus bridge.
- The FSM, grant logic and port registers live in unified_mem_arbiter.

Test Plan:
- Reset: RST=0 mid-BUSY_D → mem_req=0 within the same cycle; no d_ack after release; first grant goes to D on a tie.
- Single fetch: if_req=1, if_addr=0x00000004; memory acks one cycle after mem_req with 0x20010008 → mem_addr=0x4, mem_we=0; if_ack one cycle after mem_ack, if_rdata=0x20010008; total 3 cycles.
- Store: d_req=1, d_we=1, d_addr=0x10, d_wdata=0xDEADBEEF, zero-wait memory → mem_we=1, mem_wdata=0xDEADBEEF; d_ack 2 cycles after req; d_rdata unchanged.
- Contention: if_req and d_req both held high continuously, memory always acks → grants strictly alternate D, IF, D, IF; each acked requester re-requests and is never starved.
- Timeout: TIMEOUT=4, d_req load, mem_ack never asserted → mem_req drops after 4 BUSY cycles; d_ack=1, err=1, d_rdata=0 for one cycle; a pending if_req is granted next.
- Same-cycle race: mem_ack arrives exactly on the timeout cycle → normal ack, err=0, data captured.
